// File: rtl/cmpl_adsu_split.sv
`default_nettype none
// ============================================================================
// Module   : cmpl_adsu_split
// Purpose  : Receive-side inverse of the complex add/subtract butterfly stage.
//            A serial stream of sum beats (s = a+b) and difference beats
//            (d = a-b) is paired. Each sum is paired with the difference that
//            follows it, and both operands are rebuilt:
//              a = (s + d) >>> SCALE_FACTOR,  b = (s - d) >>> SCALE_FACTOR
//            Each result is saturated to the output width.
// Ports    : clock, reset        - rising-edge clock, synchronous active-high
//                                  reset
//            add_sub             - beat type (0 = sum, 1 = difference)
//            ivalid / iready     - input handshake
//            datain_r / datain_i - signed input beat
//            ovalid / oready     - output handshake
//            dataa_r / dataa_i   - reconstructed operand a
//            datab_r / datab_i   - reconstructed operand b
//            err                 - one-cycle pulse after a pairing violation
// Revision : 1.0 - initial release
// ============================================================================

// One arithmetic lane: sign-extend, add or subtract, floor-shift, saturate.
module cmpl_adsu_split_lane #(
  parameter int WI    = 16,
  parameter int WO    = 16,
  parameter int SCALE = 1,
  parameter bit SUB   = 1'b0
) (
  input  logic signed [WI-1:0] s_i,
  input  logic signed [WI-1:0] d_i,
  output logic signed [WO-1:0] y_o
);
  // The working width holds the full WI+1 bit sum. It is also one bit wider
  // than the output, so the saturation limits can be compared directly.
  localparam int CW = (((WI + 1) > WO) ? (WI + 1) : WO) + 1;
  localparam logic signed [CW-1:0] C_MAX = CW'((64'sd1 <<< (WO - 1)) - 64'sd1);
  localparam logic signed [CW-1:0] C_MIN = CW'(-(64'sd1 <<< (WO - 1)));

  logic signed [CW-1:0] s_ext;
  logic signed [CW-1:0] d_ext;
  logic signed [CW-1:0] full;
  logic signed [CW-1:0] shifted;

  always_comb begin
    s_ext   = CW'(s_i);
    d_ext   = CW'(d_i);
    full    = SUB ? (s_ext - d_ext) : (s_ext + d_ext);
    // The arithmetic shift rounds toward minus infinity.
    shifted = full >>> SCALE;
    if (shifted > C_MAX) begin
      y_o = C_MAX[WO-1:0];
    end else if (shifted < C_MIN) begin
      y_o = C_MIN[WO-1:0];
    end else begin
      y_o = shifted[WO-1:0];
    end
  end
endmodule

module cmpl_adsu_split #(
  parameter int SCALE_FACTOR = 1,
  parameter int REAL_WIDTH_I = 16,
  parameter int IMAG_WIDTH_I = 16,
  parameter int REAL_WIDTH_O = 16,
  parameter int IMAG_WIDTH_O = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           add_sub,
  input  logic                           ivalid,
  output logic                           iready,
  input  logic signed [REAL_WIDTH_I-1:0] datain_r,
  input  logic signed [IMAG_WIDTH_I-1:0] datain_i,
  output logic                           ovalid,
  input  logic                           oready,
  output logic signed [REAL_WIDTH_O-1:0] dataa_r,
  output logic signed [IMAG_WIDTH_O-1:0] dataa_i,
  output logic signed [REAL_WIDTH_O-1:0] datab_r,
  output logic signed [IMAG_WIDTH_O-1:0] datab_i,
  output logic                           err
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HELD  = 1'b1;

  logic [0:0]                    state_q, state_d;
  logic                          ovalid_q, ovalid_d;
  logic                          err_q, err_d;
  logic signed [REAL_WIDTH_I-1:0] sum_r_q;
  logic signed [IMAG_WIDTH_I-1:0] sum_i_q;
  logic signed [REAL_WIDTH_O-1:0] a_r_q, b_r_q;
  logic signed [IMAG_WIDTH_O-1:0] a_i_q, b_i_q;

  logic                          accept;
  logic                          load_sum;
  logic                          pair_done;
  logic signed [REAL_WIDTH_O-1:0] a_r_w, b_r_w;
  logic signed [IMAG_WIDTH_O-1:0] a_i_w, b_i_w;

  // Backpressure stalls every beat type alike, sums included.
  assign iready = !ovalid_q || oready;
  assign accept = ivalid && iready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_EMPTY: if (!add_sub) state_d = S_HELD;
        S_HELD:  if (add_sub)  state_d = S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // FSM outputs. A sum that arrives while a sum is already held replaces it.
  // This keeps the most recent sum, and the stray beat is reported on err.
  always_comb begin
    load_sum  = 1'b0;
    pair_done = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      case (state_q)
        S_EMPTY: begin
          if (!add_sub) load_sum = 1'b1;
          else          err_d    = 1'b1;
        end
        S_HELD: begin
          if (add_sub) begin
            pair_done = 1'b1;
          end else begin
            load_sum = 1'b1;
            err_d    = 1'b1;
          end
        end
        default: begin
          load_sum  = 1'b0;
          pair_done = 1'b0;
          err_d     = 1'b0;
        end
      endcase
    end
  end

  // A pair that completes in the same cycle as the consumer takes the previous
  // result keeps ovalid high, so there are no bubbles at full rate.
  always_comb begin
    ovalid_d = ovalid_q;
    if (pair_done) begin
      ovalid_d = 1'b1;
    end else if (ovalid_q && oready) begin
      ovalid_d = 1'b0;
    end
  end

  cmpl_adsu_split_lane #(.WI(REAL_WIDTH_I), .WO(REAL_WIDTH_O), .SCALE(SCALE_FACTOR), .SUB(1'b0))
    u_lane_ar (.s_i(sum_r_q), .d_i(datain_r), .y_o(a_r_w));
  cmpl_adsu_split_lane #(.WI(IMAG_WIDTH_I), .WO(IMAG_WIDTH_O), .SCALE(SCALE_FACTOR), .SUB(1'b0))
    u_lane_ai (.s_i(sum_i_q), .d_i(datain_i), .y_o(a_i_w));
  cmpl_adsu_split_lane #(.WI(REAL_WIDTH_I), .WO(REAL_WIDTH_O), .SCALE(SCALE_FACTOR), .SUB(1'b1))
    u_lane_br (.s_i(sum_r_q), .d_i(datain_r), .y_o(b_r_w));
  cmpl_adsu_split_lane #(.WI(IMAG_WIDTH_I), .WO(IMAG_WIDTH_O), .SCALE(SCALE_FACTOR), .SUB(1'b1))
    u_lane_bi (.s_i(sum_i_q), .d_i(datain_i), .y_o(b_i_w));

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
      sum_r_q  <= '0;
      sum_i_q  <= '0;
      a_r_q    <= '0;
      a_i_q    <= '0;
      b_r_q    <= '0;
      b_i_q    <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
      if (load_sum) begin
        sum_r_q <= datain_r;
        sum_i_q <= datain_i;
      end
      // The output register only loads on a completed pair. A completed pair
      // can only be accepted when the slot is free or being drained, so a
      // stalled result is never overwritten.
      if (pair_done) begin
        a_r_q <= a_r_w;
        a_i_q <= a_i_w;
        b_r_q <= b_r_w;
        b_i_q <= b_i_w;
      end
    end
  end

  assign ovalid  = ovalid_q;
  assign err     = err_q;
  assign dataa_r = a_r_q;
  assign dataa_i = a_i_q;
  assign datab_r = b_r_q;
  assign datab_i = b_i_q;

endmodule
`default_nettype wire

// File: tb/tb_cmpl_adsu_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmpl_adsu_split
// Purpose  : Scoreboard bench for cmpl_adsu_split. Two instances share one
//            stimulus stream: SCALE_FACTOR=1 and SCALE_FACTOR=0. The zero
//            scale exercises saturation. A pairing model predicts the results
//            and pushes them into a queue. An independent monitor pops and
//            compares them whenever an output is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmpl_adsu_split;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic add_sub = 1'b0;
  logic ivalid = 1'b0;
  logic oready = 1'b1;
  logic signed [15:0] datain_r = '0;
  logic signed [15:0] datain_i = '0;

  logic iready1, ovalid1, err1;
  logic iready0, ovalid0, err0;
  logic signed [15:0] ar1, ai1, br1, bi1, ar0, ai0, br0, bi0;

  always #5 clock = ~clock;

  cmpl_adsu_split #(.SCALE_FACTOR(1)) u_dut1 (
    .clock(clock), .reset(reset), .add_sub(add_sub), .ivalid(ivalid), .iready(iready1),
    .datain_r(datain_r), .datain_i(datain_i), .ovalid(ovalid1), .oready(oready),
    .dataa_r(ar1), .dataa_i(ai1), .datab_r(br1), .datab_i(bi1), .err(err1));

  cmpl_adsu_split #(.SCALE_FACTOR(0)) u_dut0 (
    .clock(clock), .reset(reset), .add_sub(add_sub), .ivalid(ivalid), .iready(iready0),
    .datain_r(datain_r), .datain_i(datain_i), .ovalid(ovalid0), .oready(oready),
    .dataa_r(ar0), .dataa_i(ai0), .datab_r(br0), .datab_i(bi0), .err(err0));

  typedef struct {
    int ar1, ai1, br1, bi1;
    int ar0, ai0, br0, bi0;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   held_m = 0;
  bit   ov_m = 0;
  int   s_r = 0, s_i = 0;
  logic err_exp = 1'b0;
  logic ov_exp = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Floor division by 2^sc.
  function automatic int fdiv(input int v, input int sc);
    int p;
    int r;
    p = 1 << sc;
    r = v / p;
    if ((v % p != 0) && (v < 0)) r = r - 1;
    return r;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(input int sr, input int si, input int dr, input int di);
    exp_t e;
    e.ar1 = sat16(fdiv(sr + dr, 1)); e.ai1 = sat16(fdiv(si + di, 1));
    e.br1 = sat16(fdiv(sr - dr, 1)); e.bi1 = sat16(fdiv(si - di, 1));
    e.ar0 = sat16(sr + dr);          e.ai0 = sat16(si + di);
    e.br0 = sat16(sr - dr);          e.bi0 = sat16(si - di);
    return e;
  endfunction

  // One clock cycle of stimulus plus the model update for that cycle.
  task automatic step(input bit rst, input bit iv, input bit as, input int r, input int im,
                      input bit ordy);
    bit rdy_m;
    bit nerr;
    @(negedge clock);
    reset    = rst;
    ivalid   = iv;
    add_sub  = as;
    datain_r = 16'(r);
    datain_i = 16'(im);
    oready   = ordy;
    #1;
    rdy_m = !ov_m || ordy;
    check("iready_s1", int'(iready1), int'(rdy_m));
    check("iready_s0", int'(iready0), int'(rdy_m));
    nerr = 1'b0;
    if (rst) begin
      held_m = 0;
      ov_m   = 0;
      q.delete();
    end else begin
      if (ov_m && ordy) ov_m = 0;
      if (iv && rdy_m) begin
        if (!as) begin
          if (held_m) nerr = 1'b1;
          held_m = 1;
          s_r = r;
          s_i = im;
        end else if (held_m) begin
          q.push_back(model(s_r, s_i, r, im));
          ov_m   = 1;
          held_m = 0;
        end else begin
          nerr = 1'b1;
        end
      end
    end
    @(posedge clock);
    err_exp = nerr;
    ov_exp  = ov_m;
  endtask

  // Monitor: samples after the driver has settled each cycle's inputs.
  always begin
    exp_t e;
    @(negedge clock);
    #2;
    if (!reset) begin
      check("ovalid_s1", int'(ovalid1), int'(ov_exp));
      check("ovalid_s0", int'(ovalid0), int'(ov_exp));
      check("err_s1", int'(err1), int'(err_exp));
      check("err_s0", int'(err0), int'(err_exp));
      if (ovalid1) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = q[0];
          check("a_r_s1", int'(ar1), e.ar1); check("a_i_s1", int'(ai1), e.ai1);
          check("b_r_s1", int'(br1), e.br1); check("b_i_s1", int'(bi1), e.bi1);
          check("a_r_s0", int'(ar0), e.ar0); check("a_i_s0", int'(ai0), e.ai0);
          check("b_r_s0", int'(br0), e.br0); check("b_i_s0", int'(bi0), e.bi0);
          if (oready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit next_as;
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    #3;
    check("rst_ovalid", int'(ovalid1), 0);
    check("rst_err", int'(err1), 0);
    check("rst_iready", int'(iready1), 1);
    check("rst_a_r", int'(ar1), 0); check("rst_a_i", int'(ai1), 0);
    check("rst_b_r", int'(br1), 0); check("rst_b_i", int'(bi1), 0);

    // Directed pairs, back-to-back at full rate
    step(0, 1, 0, 4, 6, 1);        step(0, 1, 1, 2, 2, 1);
    step(0, 1, 0, 1, 1, 1);        step(0, 1, 1, -7, 3, 1);
    step(0, 1, 0, 3, -3, 1);       step(0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 32767, -32768, 1); step(0, 1, 1, 32767, 1, 1);
    // Pairing errors
    step(0, 1, 1, 5, 5, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 9, 9, 1);        step(0, 1, 0, 4, 6, 1);  step(0, 1, 1, 2, 2, 1);
    // Backpressure: the result stalls while a sum waits at the input
    step(0, 1, 0, 5, 5, 1);        step(0, 1, 1, 1, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 10, 10, 0);
    step(0, 1, 0, 10, 10, 1);      step(0, 1, 1, 2, 4, 1);
    step(0, 1, 0, 8, 8, 1);
    // Reset mid-pair: the held sum is lost, so the diff is an error
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic, mostly alternating beat types
    next_as = 0;
    for (int k = 0; k < 3000; k++) begin
      bit iv, as, ordy, rst;
      iv   = ($urandom % 4) != 0;
      as   = (($urandom % 8) == 0) ? 1'($urandom) : next_as;
      ordy = ($urandom % 3) != 0;
      rst  = ($urandom % 250) == 0;
      if (iv && (!ov_m || ordy) && !rst) next_as = !as;
      if (rst) next_as = 0;
      step(rst, iv, as, $urandom_range(0, 65535) - 32768,
           $urandom_range(0, 65535) - 32768, ordy);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cmpl_adsu_split.md
# cmpl_adsu_split

Inverse stage to the complex add/subtract block. It takes a serial stream of complex sum beats (a+b) and difference beats (a−b), pairs each sum with the difference that follows it, and reconstructs both operands: a = (s+d)/2^SCALE_FACTOR and b = (s−d)/2^SCALE_FACTOR. It sits on the receive side of a butterfly link, with a valid/ready handshake on both ports. An error pulse flags pairing violations.

## Interface
- SCALE_FACTOR, 1, arithmetic right-shift applied after add/sub (1 = exact inverse of the unscaled adder)
- REAL_WIDTH_I, 16, signed width of input real part
- IMAG_WIDTH_I, 16, signed width of input imaginary part
- REAL_WIDTH_O, 16, signed width of output real parts
- IMAG_WIDTH_O, 16, signed width of output imaginary parts

- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- add_sub  in  1  beat type: 0 = sum beat (s), 1 = difference beat (d)
- ivalid  in  1  input beat valid
- iready  out  1  input ready; a beat is accepted when ivalid && iready
- datain_r  in  REAL_WIDTH_I  signed input real part
- datain_i  in  IMAG_WIDTH_I  signed input imaginary part
- ovalid  out  1  operand pair valid
- oready  in  1  downstream ready
- dataa_r / dataa_i  out  REAL_WIDTH_O / IMAG_WIDTH_O  reconstructed a
- datab_r / datab_i  out  REAL_WIDTH_O / IMAG_WIDTH_O  reconstructed b
- err  out  1  one-cycle pulse on a pairing violation

## Operation
- Pairing FSM states: EMPTY (no sum held) and HELD (sum register valid). Reset puts the FSM in EMPTY.
- EMPTY:
  - Accepted sum: store it in the sum register and go to HELD.
  - Accepted difference: drop it, pulse err, stay in EMPTY.
- HELD:
  - Accepted difference: compute both operands, load the output register, set ovalid, go to EMPTY.
  - Accepted sum: overwrite the held sum, pulse err, stay in HELD.
- Arithmetic, per component (real and imaginary independently):
  - Sign-extend s and d to input width+1.
  - Form s+d and s−d with no overflow.
  - Arithmetic shift right by SCALE_FACTOR (floor rounding toward −inf).
  - Saturate to the output width: max positive 2^(W−1)−1, min −2^(W−1).
- The output register holds its value while ovalid && !oready.
- ovalid clears on (ovalid && oready) unless a new pair completes in the same cycle; in that case ovalid stays 1 with the new data.
- iready = !ovalid || oready. It does not depend on beat type, so sums are also stalled under backpressure (a simple, uniform rule).
- err is registered; it is asserted only in the cycle after the offending accept.

## Timing
- Reset values: ovalid=0, err=0, dataa_*=0, datab_*=0, FSM=EMPTY, sum register=0. iready=1 after reset (because ovalid=0).
- Latency: a difference accepted in cycle N gives ovalid=1 with the result in cycle N+1.
- Throughput: one pair per 2 accepted beats; back-to-back sum/diff/sum/diff with oready=1 runs at full rate with no bubbles.
- Reset asserted mid-pair: the held sum is discarded, and any pending output is dropped (ovalid=0 next cycle).
- ivalid with iready=0: nothing is accepted, and the FSM and sum register are unchanged.
- ivalid=0: the FSM is unchanged and err=0.

## Test plan
- Sum (4,6), then diff (2,2), oready=1 -> one cycle after the diff, ovalid=1 with a=(3,4), b=(1,2); err stays 0.
- Sum (1,1), then diff (−7,3) -> a=(−3,2), b=(4,−1), checked in two's complement.
- Odd and negative rounding: sum (3,−3), diff (0,0) -> a=b=(1,−2).
- Saturation with SCALE_FACTOR=0: sum (32767,−32768), diff (32767,1) -> a=(32767,−32767), b=(0,−32768); a_r saturated.
- Pairing errors:
  - diff beat in EMPTY -> err pulse, no ovalid.
  - sum (9,9), then sum (4,6), then diff (2,2) -> err pulse on the second sum; result is a=(3,4), b=(1,2).
- Backpressure: hold oready=0 after a pair completes -> iready=0, and outputs stay stable for 5 cycles. Raise oready together with a pending diff -> the next pair appears the following cycle with ovalid held high. Then assert reset mid-pair -> ovalid=0 and FSM=EMPTY next cycle.
